// File: rtl/calc_pkg.sv
// Shared types for the calculator arithmetic stage: op codes, FSM states
// and the decode rule that folds reserved op codes onto CLEAR.
package calc_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_MUL    = 3'd2,
      OP_DIV    = 3'd3,
      OP_RECALL = 3'd4,
      OP_CLEAR  = 3'd5
   } calc_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DIV  = 1'b1
   } calc_state_e;

   // Op codes at or above this value (CLEAR and the reserved 6/7) produce 0.
   localparam logic [2:0] OP_CLEAR_MIN = 3'd5;

   function automatic calc_op_e decode_op(input logic [2:0] code);
      if (code >= OP_CLEAR_MIN) begin
         return OP_CLEAR;
      end
      return calc_op_e'(code);
   endfunction

endpackage

// File: rtl/calc_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// done is high during the final iteration cycle and quotient then carries
// the completed result, so the caller can register it on that same edge.
module calc_div_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient
);

   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] quo_q;
   logic [DATA_WIDTH-1:0] dvs_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  active_q;

   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
   logic                  fits;
   logic [DATA_WIDTH-1:0] rem_next;
   logic [DATA_WIDTH-1:0] quo_next;

   // One restoring step: bring down the next dividend bit, try the subtract.
   always_comb begin
      shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      fits     = ~diff[DATA_WIDTH];
      rem_next = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
      quo_next = {quo_q[DATA_WIDTH-2:0], fits};
   end

   assign done     = active_q && (cnt_q == '0);
   assign quotient = quo_next;

   // Iteration registers: load on start, then step until the counter hits 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         rem_q    <= '0;
         quo_q    <= dividend;
         dvs_q    <= divisor;
         cnt_q    <= CNT_WIDTH'(DATA_WIDTH - 1);
         active_q <= 1'b1;
      end else if (active_q) begin
         rem_q <= rem_next;
         quo_q <= quo_next;
         if (cnt_q == '0) begin
            active_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential arithmetic stage feeding the result-memory enable flop.
// Handshake: a transfer happens on a rising edge where calc_in_valid and
// calc_in_ready are both high; operands, op and use_mem are captured only
// then. Ready drops for the cycle carrying calc_res_en so the downstream
// flop has updated before the next use_mem operation samples calc_mem_q.
module calc_alu_seq
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  calc_clk,
   input  logic                  calc_rst,
   input  logic                  calc_in_valid,
   output logic                  calc_in_ready,
   input  logic [2:0]            calc_op,
   input  logic                  calc_use_mem,
   input  logic [DATA_WIDTH-1:0] calc_val1,
   input  logic [DATA_WIDTH-1:0] calc_val2,
   input  logic [DATA_WIDTH-1:0] calc_mem_q,
   output logic [DATA_WIDTH-1:0] calc_res_d,
   output logic                  calc_res_en,
   output logic                  calc_div_zero,
   output logic                  calc_busy
);

   calc_state_e           state_q;
   calc_op_e              op;
   logic                  transfer;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  div_start;
   logic                  div_done;
   logic [DATA_WIDTH-1:0] div_quot;

   assign calc_in_ready = (state_q == ST_IDLE) && !calc_res_en && !calc_rst;
   assign calc_busy     = (state_q == ST_DIV);
   assign transfer      = calc_in_valid && calc_in_ready;
   assign op            = decode_op(calc_op);
   assign op_a          = calc_use_mem ? calc_mem_q : calc_val1;
   assign div_start     = transfer && (op == OP_DIV) && (calc_val2 != '0);

   // Single-cycle result for every op except DIV.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:    alu_res = op_a + calc_val2;
         OP_SUB:    alu_res = op_a - calc_val2;
         OP_MUL:    alu_res = op_a * calc_val2;
         OP_RECALL: alu_res = op_a;
         default:   alu_res = '0;
      endcase
   end

   calc_div_iter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_div (
      .clk      (calc_clk),
      .rst      (calc_rst),
      .start    (div_start),
      .dividend (op_a),
      .divisor  (calc_val2),
      .done     (div_done),
      .quotient (div_quot)
   );

   // Control FSM with registered result, write pulse and divide-by-zero flag.
   always_ff @(posedge calc_clk) begin
      if (calc_rst) begin
         state_q       <= ST_IDLE;
         calc_res_d    <= '0;
         calc_res_en   <= 1'b0;
         calc_div_zero <= 1'b0;
      end else begin
         calc_res_en   <= 1'b0;
         calc_div_zero <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (transfer) begin
                  if (op == OP_DIV) begin
                     if (calc_val2 == '0) begin
                        calc_res_d    <= '1;
                        calc_res_en   <= 1'b1;
                        calc_div_zero <= 1'b1;
                     end else begin
                        state_q <= ST_DIV;
                     end
                  end else begin
                     calc_res_d  <= alu_res;
                     calc_res_en <= 1'b1;
                  end
               end
            end
            ST_DIV: begin
               if (div_done) begin
                  calc_res_d  <= div_quot;
                  calc_res_en <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq: directed vector table, two multi-cycle corner
// sequences, and randomized operations against a behavioural model.
module tb_calc_alu_seq;

   localparam int W  = 32;
   localparam int EW = W + 1;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic         use_mem;
   logic [W-1:0] val1;
   logic [W-1:0] val2;
   logic [W-1:0] mem_q;
   logic [W-1:0] res_d;
   logic         res_en;
   logic         div_zero;
   logic         busy;

   always #5 clk = ~clk;

   calc_alu_seq #(.DATA_WIDTH(W)) dut (
      .calc_clk      (clk),
      .calc_rst      (rst),
      .calc_in_valid (in_valid),
      .calc_in_ready (in_ready),
      .calc_op       (op),
      .calc_use_mem  (use_mem),
      .calc_val1     (val1),
      .calc_val2     (val2),
      .calc_mem_q    (mem_q),
      .calc_res_d    (res_d),
      .calc_res_en   (res_en),
      .calc_div_zero (div_zero),
      .calc_busy     (busy)
   );

   // Downstream result flop: d = res_d, en = res_en.
   always @(posedge clk) begin
      if (rst) mem_q <= '0;
      else if (res_en) mem_q <= res_d;
   end

   // ---------------- scoreboard ----------------
   int             checks = 0;
   int             errors = 0;
   logic [EW-1:0]  exp_q[$];      // {div_zero, result}
   logic [W-1:0]   model_mem;     // expected content of the result flop

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: result of one operation from the op rules.
   function automatic logic [EW-1:0] model(input logic [2:0] code, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         dz;
      dz = 1'b0;
      case (code)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a * b;
         3'd3: begin
            if (b == 0) begin
               r  = {W{1'b1}};
               dz = 1'b1;
            end else begin
               r = a / b;
            end
         end
         3'd4: r = a;
         default: r = '0;
      endcase
      return {dz, r};
   endfunction

   // Every write pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (res_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_res_en: res_d 0x%0h with nothing pending at %0t", res_d, $time);
            end else begin
               check("result", {div_zero, res_d}, exp_q.pop_front());
            end
         end else begin
            check("div_zero_idle", {{W{1'b0}}, div_zero}, '0);
         end
      end
   end

   // ---------------- driver ----------------
   // Issue one operation, then check latency, busy span and the ready bubble.
   task automatic send(input logic [2:0] code, input logic um, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic [EW-1:0] exp);
      int n;
      int lat;
      int busy_cnt;
      int exp_lat;
      exp_lat = (code == 3'd3 && v2 != 0) ? W + 1 : 1;
      @(negedge clk);
      op = code; use_mem = um; val1 = v1; val2 = v2; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles", n);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      // Scramble the inputs: the captured operation must be unaffected.
      in_valid = 1'b0;
      op = 3'($urandom_range(0, 7)); use_mem = ~um; val1 = $urandom; val2 = $urandom;
      lat = 1;
      busy_cnt = 0;
      while (!res_en && lat < 200) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check("latency", EW'(lat), EW'(exp_lat));
      check("busy_cycles", EW'(busy_cnt), EW'(exp_lat - 1));
      check("ready_in_pulse", {{W{1'b0}}, in_ready}, '0);
      @(negedge clk);
      check("ready_after_pulse", {{W{1'b0}}, in_ready}, EW'(1));
      model_mem = exp[W-1:0];
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [2:0]   op;
      logic         um;
      logic [W-1:0] v1;
      logic [W-1:0] v2;
      logic [W-1:0] res;
      logic         dz;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [2:0]   r_op;
      logic         r_um;
      logic [W-1:0] r_v1;
      logic [W-1:0] r_v2;
      logic [W-1:0] a;

      vecs[0]  = '{3'd0, 1'b0, 32'd7,          32'd5,          32'd12,         1'b0};
      vecs[1]  = '{3'd1, 1'b0, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
      vecs[2]  = '{3'd2, 1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0};
      vecs[3]  = '{3'd0, 1'b0, 32'd10,         32'd0,          32'd10,         1'b0};
      vecs[4]  = '{3'd0, 1'b1, 32'hDEAD_BEEF,  32'd4,          32'd14,         1'b0};
      vecs[5]  = '{3'd3, 1'b0, 32'd100,        32'd7,          32'd14,         1'b0};
      vecs[6]  = '{3'd3, 1'b0, 32'd9,          32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[7]  = '{3'd4, 1'b1, 32'd55,         32'd66,         32'hFFFF_FFFF,  1'b0};
      vecs[8]  = '{3'd0, 1'b1, 32'd0,          32'd2,          32'd1,          1'b0};
      vecs[9]  = '{3'd4, 1'b0, 32'h1234_5678,  32'd9,          32'h1234_5678,  1'b0};
      vecs[10] = '{3'd5, 1'b0, 32'd5,          32'd6,          32'd0,          1'b0};
      vecs[11] = '{3'd6, 1'b0, 32'd5,          32'd6,          32'd0,          1'b0};
      vecs[12] = '{3'd7, 1'b0, 32'd5,          32'd6,          32'd0,          1'b0};
      vecs[13] = '{3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
      vecs[14] = '{3'd3, 1'b0, 32'd5,          32'd7,          32'd0,          1'b0};
      vecs[15] = '{3'd2, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};
      vecs[16] = '{3'd1, 1'b1, 32'd77,         32'd1,          32'd0,          1'b0};
      vecs[17] = '{3'd3, 1'b0, 32'h8000_0000,  32'h0000_0010,  32'h0800_0000,  1'b0};

      // Reset
      rst = 1'b1; in_valid = 1'b0; op = '0; use_mem = 1'b0; val1 = '0; val2 = '0;
      model_mem = '0;
      repeat (2) @(negedge clk);
      check("reset_res_d", {1'b0, res_d}, '0);
      check("reset_res_en", {{W{1'b0}}, res_en}, '0);
      check("reset_div_zero", {{W{1'b0}}, div_zero}, '0);
      check("reset_busy", {{W{1'b0}}, busy}, '0);
      check("reset_in_ready", {{W{1'b0}}, in_ready}, '0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {{W{1'b0}}, in_ready}, EW'(1));

      // Vector table
      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].um, vecs[i].v1, vecs[i].v2, {vecs[i].dz, vecs[i].res});
      end

      // Valid held through a divide, with the request changed mid-way
      @(negedge clk);
      op = 3'd3; use_mem = 1'b0; val1 = 32'd100; val2 = 32'd7; in_valid = 1'b1;
      check("div_hold_ready", {{W{1'b0}}, in_ready}, EW'(1));
      exp_q.push_back({1'b0, 32'd14});
      @(posedge clk);
      @(negedge clk);
      op = 3'd0; val1 = 32'd1; val2 = 32'd1;
      pulses = 1;
      while (!res_en && pulses < 200) begin
         check("ready_while_busy", {{W{1'b0}}, in_ready}, '0);
         @(negedge clk);
         pulses++;
      end
      check("div_hold_latency", EW'(pulses), EW'(W + 1));
      exp_q.push_back({1'b0, 32'd2});
      @(negedge clk);
      check("ready_after_div", {{W{1'b0}}, in_ready}, EW'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("add_after_div_pulse", {{W{1'b0}}, res_en}, EW'(1));
      model_mem = 32'd2;
      @(negedge clk);

      // Reset during the 10th divide iteration
      op = 3'd3; use_mem = 1'b0; val1 = 32'd1000; val2 = 32'd3; in_valid = 1'b1;
      check("abort_ready", {{W{1'b0}}, in_ready}, EW'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", {{W{1'b0}}, busy}, EW'(1));
      rst = 1'b1;
      @(negedge clk);
      check("abort_res_d", {1'b0, res_d}, '0);
      check("abort_res_en", {{W{1'b0}}, res_en}, '0);
      check("abort_busy", {{W{1'b0}}, busy}, '0);
      check("abort_div_zero", {{W{1'b0}}, div_zero}, '0);
      check("abort_ready_in_reset", {{W{1'b0}}, in_ready}, '0);
      rst = 1'b0;
      model_mem = '0;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (res_en) pulses++;
      end
      check("abort_no_pulse", EW'(pulses), '0);
      send(3'd0, 1'b0, 32'd1, 32'd1, {1'b0, 32'd2});

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_um = 1'($urandom_range(0, 1));
         r_v1 = $urandom;
         case ($urandom_range(0, 3))
            0:       r_v2 = '0;
            1:       r_v2 = W'($urandom_range(1, 15));
            default: r_v2 = $urandom;
         endcase
         a = r_um ? model_mem : r_v1;
         send(r_op, r_um, r_v1, r_v2, model(r_op, a, r_v2));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", EW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
